// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line transmitter and its CRC7 engine.
package sd_pkg;

    localparam int FRAME_BITS   = 48;
    localparam int PAYLOAD_BITS = 40;

    // x^7 + x^3 + 1; bit 7 is the implicit leading term.
    localparam logic [7:0] CRC7_POLY = 8'h89;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRC_LOAD,
        ST_CRC_WAIT,
        ST_SEND,
        ST_FINISH
    } state_t;

    // Standard command indices.
    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD17 = 6'd17;

endpackage

// File: rtl/crc7.sv
// Bit-serial CRC7 over a WIDTH-bit word, MSB first, one bit per clock.
// crc_ready falls on the edge that accepts load and rises once the last
// bit has been folded in; it then stays high until the next load.
module crc7
    import sd_pkg::*;
#(
    parameter int WIDTH = PAYLOAD_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [6:0]       crc,
    output logic             crc_ready
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    remaining;
    logic             fb;

    assign fb = shreg[WIDTH-1] ^ crc[6];

    // Shift the captured word through the CRC LFSR, counting bits left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            remaining <= '0;
            crc       <= '0;
            crc_ready <= 1'b0;
        end else if (load) begin
            shreg     <= data_in;
            remaining <= CW'(WIDTH);
            crc       <= '0;
            crc_ready <= 1'b0;
        end else if (remaining != '0) begin
            shreg     <= {shreg[WIDTH-2:0], 1'b0};
            crc       <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY[6:0] : 7'd0);
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
                crc_ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter: builds the 48-bit command frame (with CRC7
// from the crc7 engine) and shifts it out MSB first on bit_en strobes,
// driving the CMD tristate enable.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int TAIL_BITS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    input  logic        bit_en,
    output logic        busy,
    output logic        done,
    output logic        cmd_out,
    output logic        cmd_oe
);

    localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);
    localparam logic [3:0] TAIL_CNT  = 4'(TAIL_BITS);

    state_t                  state;
    state_t                  state_nxt;
    logic [PAYLOAD_BITS-1:0] payload;
    logic [FRAME_BITS-1:0]   frame;
    logic [5:0]              bit_cnt;
    logic [3:0]              tail_cnt;
    logic                    tail_more;
    logic                    crc_load;
    logic [6:0]              crc;
    logic                    crc_ready;

    assign tail_more = (tail_cnt < TAIL_CNT);

    crc7 #(
        .WIDTH (PAYLOAD_BITS)
    ) u_crc7 (
        .clk       (clk),
        .reset     (reset),
        .load      (crc_load),
        .data_in   (payload),
        .crc       (crc),
        .crc_ready (crc_ready)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; busy stays high through the done cycle, so a start
    // coincident with done is not accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start && !busy) state_nxt = ST_CRC_LOAD;
            ST_CRC_LOAD: state_nxt = ST_CRC_WAIT;
            ST_CRC_WAIT: if (crc_ready) state_nxt = ST_SEND;
            ST_SEND:     if (bit_en && (bit_cnt == FRAME_CNT)) state_nxt = ST_FINISH;
            ST_FINISH:   if (bit_en && !tail_more) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: the CRC load strobe lasts exactly the CRC_LOAD cycle.
    always_comb begin
        crc_load = 1'b0;
        if (state == ST_CRC_LOAD) begin
            crc_load = 1'b1;
        end
    end

    // Payload/frame capture, serial shifter, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            cmd_out  <= 1'b1;
            cmd_oe   <= 1'b0;
            bit_cnt  <= '0;
            tail_cnt <= '0;
            frame    <= '0;
            payload  <= '0;
        end else begin
            done <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start && !busy) begin
                        payload <= {1'b0, 1'b1, cmd_index, argument};
                        busy    <= 1'b1;
                    end
                end
                ST_CRC_WAIT: begin
                    if (crc_ready) begin
                        frame   <= {payload, crc, 1'b1};
                        bit_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (bit_en) begin
                        if (bit_cnt < FRAME_CNT) begin
                            cmd_out <= frame[FRAME_BITS-1];
                            frame   <= {frame[FRAME_BITS-2:0], 1'b0};
                            cmd_oe  <= 1'b1;
                            bit_cnt <= bit_cnt + 6'd1;
                        end else begin
                            tail_cnt <= '0;
                        end
                    end
                end
                ST_FINISH: begin
                    if (bit_en) begin
                        cmd_out <= 1'b1;
                        if (tail_more) begin
                            cmd_oe   <= 1'b1;
                            tail_cnt <= tail_cnt + 4'd1;
                        end else begin
                            cmd_oe <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Testbench for sd_cmd_tx: table-driven commands, hand-written corner
// sequences and randomized commands against a polynomial-division CRC model.
module tb_sd_cmd_tx;
    import sd_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_en = 1'b0;
    logic        start0 = 1'b0;
    logic        start2 = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] argument = '0;
    logic        busy0, done0, out0, oe0;
    logic        busy2, done2, out2, oe2;

    int checks = 0;
    int errors = 0;
    int period = 4;
    int phase  = 0;
    logic rx0[$];
    logic rx2[$];
    int   dn0 = 0;
    int   dn2 = 0;
    logic be_s;

    sd_cmd_tx #(.TAIL_BITS(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .cmd_index(cmd_index),
        .argument(argument), .bit_en(bit_en), .busy(busy0), .done(done0),
        .cmd_out(out0), .cmd_oe(oe0)
    );

    sd_cmd_tx #(.TAIL_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cmd_index(cmd_index),
        .argument(argument), .bit_en(bit_en), .busy(busy2), .done(done2),
        .cmd_out(out2), .cmd_oe(oe2)
    );

    always #5 clk = ~clk;

    // SD clock strobe: one cycle high every 'period' clocks.
    always @(negedge clk) begin
        phase  = (phase + 1 >= period) ? 0 : phase + 1;
        bit_en = (phase == 0);
    end

    // Line monitor: every strobe that leaves the line driven yields one bit.
    always @(posedge clk) begin
        be_s = bit_en;
        #1;
        if (be_s && oe0) rx0.push_back(out0);
        if (be_s && oe2) rx2.push_back(out2);
        if (done0) dn0++;
        if (done2) dn2++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC7 as the remainder of (payload * x^7) divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc_ref(input logic [39:0] d);
        logic [46:0] m;
        logic [46:0] p;
        m = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (m[i]) begin
                p = 47'(CRC7_POLY) << (i - 7);
                m = m ^ p;
            end
        end
        return m[6:0];
    endfunction

    function automatic logic rxbit(input bit sel, input int i);
        return sel ? rx2[i] : rx0[i];
    endfunction

    task automatic run_cmd(input bit sel, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc_exp, input bit inj, input bit inj_done,
                           input bit b2b, input string nm);
        int          tail;
        int          n;
        bit          seen;
        bit          ok;
        logic [47:0] exp_frame;
        logic [47:0] got;
        tail      = sel ? 2 : 0;
        exp_frame = {2'b01, idx, arg, crc_exp, 1'b1};
        rx0.delete(); rx2.delete(); dn0 = 0; dn2 = 0;
        if (!b2b) @(negedge clk);
        cmd_index = idx; argument = arg;
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0;
        chk({nm, " busy after start"}, sel ? busy2 : busy0, 1);
        seen = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start0 = 1'b0; start2 = 1'b0;
            if (sel ? done2 : done0) begin
                seen = 1;
                break;
            end
            if (inj && (cyc == 3 || cyc == 150)) begin
                cmd_index = idx ^ 6'h2A; argument = ~arg;
                if (sel) start2 = 1'b1; else start0 = 1'b1;
            end
        end
        chk({nm, " done seen"}, seen, 1);
        if (!seen) return;
        chk({nm, " busy/oe/out at done"},
            sel ? {busy2, oe2, out2} : {busy0, oe0, out0}, 3'b101);
        if (inj_done) begin
            cmd_index = 6'h3F; argument = 32'hDEAD_BEEF;
            if (sel) start2 = 1'b1; else start0 = 1'b1;
        end
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0;
        chk({nm, " busy after done"}, sel ? busy2 : busy0, 0);
        n = sel ? rx2.size() : rx0.size();
        chk({nm, " driven strobes"}, n, 49 + tail);
        got = '0;
        for (int i = 0; i < 48; i++) got = {got[46:0], (i < n) ? rxbit(sel, i) : 1'b0};
        chk({nm, " frame"}, got, exp_frame);
        ok = 1;
        for (int i = 48; i < n; i++) if (rxbit(sel, i) !== 1'b1) ok = 0;
        chk({nm, " end/tail high"}, ok, 1);
        chk({nm, " done count"}, sel ? dn2 : dn0, 1);
    endtask

    typedef struct {
        bit          sel;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        int          per;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [5:0]  ridx;
        logic [31:0] rarg;
        tbl[0] = '{1'b0, CMD0,  32'h0000_0000, 7'h4A, 4};
        tbl[1] = '{1'b0, CMD8,  32'h0000_01AA, 7'h43, 4};
        tbl[2] = '{1'b1, CMD17, 32'h0000_0000, 7'h2A, 4};
        tbl[3] = '{1'b0, CMD8,  32'h0000_01AA, 7'h43, 1};
        tbl[4] = '{1'b1, CMD0,  32'h0000_0000, 7'h4A, 3};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset state dut0", {busy0, done0, oe0, out0}, 4'b0001);
        chk("reset state dut2", {busy2, done2, oe2, out2}, 4'b0001);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            period = tbl[i].per;
            run_cmd(tbl[i].sel, tbl[i].idx, tbl[i].arg, tbl[i].crc, 0, 0, 0, $sformatf("vec%0d", i));
        end

        // Start pulses in CRC_WAIT, in SEND and in the done cycle are ignored.
        period = 4;
        run_cmd(0, CMD8, 32'h0000_01AA, 7'h43, 1, 1, 0, "ignore starts");

        // Reset in the middle of a CMD17 frame.
        rx0.delete(); dn0 = 0;
        @(negedge clk);
        cmd_index = CMD17; argument = 32'h0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (rx0.size() >= 21) break;
        end
        chk("midframe reached bit 20", rx0.size() >= 21, 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset outputs", {busy0, done0, oe0, out0}, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("no done after reset", dn0, 0);
        chk("idle after reset", {busy0, oe0, out0}, 3'b001);
        run_cmd(0, CMD0, 32'h0, 7'h4A, 0, 0, 0, "cmd0 after reset");

        // Continuous strobes and back-to-back commands.
        period = 1;
        run_cmd(0, CMD17, 32'h0, 7'h2A, 0, 0, 0, "cont cmd17");
        run_cmd(0, CMD0, 32'h0, 7'h4A, 0, 0, 1, "b2b cmd0");
        run_cmd(1, CMD8, 32'h0000_01AA, 7'h43, 0, 0, 0, "cont tail cmd8");
        run_cmd(1, CMD17, 32'h1234_5678, crc_ref({2'b01, CMD17, 32'h1234_5678}), 0, 0, 1, "b2b tail");

        // Randomized commands against the reference CRC.
        for (int k = 0; k < 8; k++) begin
            ridx   = 6'($urandom);
            rarg   = $urandom;
            period = $urandom_range(1, 5);
            run_cmd(k[0], ridx, rarg, crc_ref({2'b01, ridx, rarg}), 0, 0, 0, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
